register_file_wb: RTL

Architectural integer register file for the RISC-V pipeline. Its write port is the consumer end of the MEM/WB pipeline register. It stores 32 × 32-bit registers, performs the writeback on the clock edge, and serves two combinational read ports to the decode stage. An optional internal bypass forwards same-cycle writeback data to the readers, so no separate WB→ID forwarding mux is required.

---
 rtl/register_file_wb.sv | 93 +++++++++
 1 files changed

// File: rtl/register_file_wb.sv
// register_file_wb: 32 x DATA_W architectural integer register file.
// Write port is the consumer end of the MEM/WB pipeline register; two
// combinational read ports serve the decode stage. x0 has no storage.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data to the read ports (suppressed while reset is asserted).
//
// Write-port handshake: Reg_W_i acts as the valid qualifier for
// {Reg_D_i, Data_to_reg_i}; there is no ready, because the file accepts a
// write on every rising edge outside reset. A write to x0 is accepted and
// dropped without touching storage or the write counter.
module register_file_wb #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              Reg_W_i,
    input  logic [4:0]        Reg_D_i,
    input  logic [DATA_W-1:0] Data_to_reg_i,
    input  logic [4:0]        Rs1_i,
    input  logic [4:0]        Rs2_i,
    output logic [DATA_W-1:0] Rs1_data_o,
    output logic [DATA_W-1:0] Rs2_data_o,
    output logic [15:0]       Wr_count_o
);

    logic [DATA_W-1:0] regs_q [1:31];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;
    logic              wr_en;

    // A write commits only when enabled and not aimed at x0.
    assign wr_en = Reg_W_i && (Reg_D_i != 5'd0);

    // Committed-write counter; wraps naturally at 16 bits.
    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_en) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    // Register storage and counter; async reset loads sp/gp init values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 2) begin
                    regs_q[i] <= SP_INIT;
                end else if (i == 3) begin
                    regs_q[i] <= GP_INIT;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            wr_count_q <= 16'd0;
        end else begin
            if (wr_en) begin
                regs_q[Reg_D_i] <= Data_to_reg_i;
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Read port 1: x0 reads zero; otherwise stored value or bypassed data.
    always_comb begin
        Rs1_data_o = '0;
        if (Rs1_i != 5'd0) begin
            Rs1_data_o = regs_q[Rs1_i];
        end
`ifdef REGFILE_BYPASS_EN
        if (reset_i && wr_en && (Rs1_i == Reg_D_i)) begin
            Rs1_data_o = Data_to_reg_i;
        end
`endif
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        Rs2_data_o = '0;
        if (Rs2_i != 5'd0) begin
            Rs2_data_o = regs_q[Rs2_i];
        end
`ifdef REGFILE_BYPASS_EN
        if (reset_i && wr_en && (Rs2_i == Reg_D_i)) begin
            Rs2_data_o = Data_to_reg_i;
        end
`endif
    end

    assign Wr_count_o = wr_count_q;

endmodule
